downcount_seq_checker: RTL
==========================

Name: downcount_seq_checker

Overview:
- Downstream monitor for the 4-bit synchronous down counter; consumes its Q0..Q3 outputs on the same clock.
- Checks that each sampled value is exactly the previous value minus 1, modulo 16.
- Reports lock status, decrement errors and terminal-count wrap events (0000 -> 1111).
- Used on the lab board and in benches as a self-checking consumer of the counter.

Parameters:
LOCK_N, 3, consecutive correct decrements needed to declare lock (legal 1..15)
ERR_W, 8, width of the saturating error counter
WRAP_W, 8, width of the wrapping wrap-event counter

Ports:
clk  input  1  single system clock, rising edge
clr_bar  input  1  synchronous active-low reset, sampled on rising edge of clk
en  input  1  sample strobe; Q inputs evaluated only on edges where en=1
Q0  input  1  counter bit 0 (LSB)
Q1  input  1  counter bit 1
Q2  input  1  counter bit 2
Q3  input  1  counter bit 3 (MSB)
locked  output  1  high while the sequence is tracked correctly
err  output  1  one-cycle pulse on a decrement mismatch while locked
wrap  output  1  one-cycle pulse on a 0000->1111 step while locked
err_cnt  output  ERR_W  count of err pulses, saturating at all-ones
wrap_cnt  output  WRAP_W  count of wrap pulses, wraps modulo 2^WRAP_W
last_q  output  4  most recently accepted sample {Q3,Q2,Q1,Q0}

Behaviour:
Input and clocking
- q = {Q3,Q2,Q1,Q0}; exp = last_q - 1 mod 16 (4-bit wrap, 0 -> 15).
- All outputs are registered; the response to a sample appears at the edge that takes that sample (latency 1 cycle from input setup).

Reset
- clr_bar=0 at a rising edge: state <= IDLE.
- locked, err, wrap, err_cnt, wrap_cnt, last_q and internal run counter all <= 0.
- Reset has priority over en and over any state, including mid-LOCK.

General rules
- en=0: state, last_q, run and counters hold; err and wrap are 0.
- err and wrap are never high for more than one cycle per sample.

FSM states (IDLE, SYNC, LOCK), all transitions on edges with en=1:
- IDLE: last_q <= q; run <= 0; go to SYNC. No pulses.
- SYNC, q == exp:
  - run <= run+1.
  - If run+1 == LOCK_N: go to LOCK and set locked=1 at the same edge.
- SYNC, q != exp: run <= 0; stay in SYNC; no err pulse.
- SYNC: last_q <= q always. No wrap pulse in SYNC, even for 0 -> 15.
- LOCK, q == exp: stay in LOCK.
  - If last_q == 0 (so q == 15): wrap=1 and wrap_cnt <= wrap_cnt+1, modulo.
- LOCK, q != exp:
  - err=1; err_cnt <= err_cnt+1, holding at 2^ERR_W-1 once reached.
  - locked <= 0; run <= 0; go to SYNC.
- LOCK: last_q <= q always. A mismatched value becomes the new reference.

Boundary conditions
- Stalled counter (q == last_q) is a mismatch.
- Counter preset (jump to 1111) or clear (jump to 0000) is a mismatch unless it happens to equal exp.
- With LOCK_N=1, a single correct step from SYNC locks.

Test Plan:
1. Reset; en=1 every cycle; feed 15,14,13,12 (LOCK_N=3) -> locked=1 at the edge sampling 12; err=0; err_cnt=0; last_q=12.
2. Continue locked through 1,0,15 -> wrap=1 for exactly one cycle at the edge sampling 15; wrap_cnt=1; locked stays 1.
3. Locked at 9, inject 5 (preset jump) -> err pulse; err_cnt=1; locked=0. Feed 4,3,2 -> locked=1 at the edge sampling 2; no further err.
4. Locked, feed 7 then 7 (stall) -> err pulse at the second 7; locked=0; last_q=7.
5. Same sequence as test 1 with en=0 on alternate cycles and Q driven to garbage on en=0 cycles -> identical locked timing in sample count; no err or wrap pulses.
6. While locked, drive clr_bar=0 for one edge -> all outputs 0 next cycle and state IDLE. Then force 260 mismatches with ERR_W=8 -> err_cnt holds at 255.

Source files
------------

// File: rtl/downcount_seq_checker.sv
// downcount_seq_checker
// ---------------------
// Monitors a 4-bit synchronous down counter. It consumes the counter bits on
// the same clock and checks that every accepted sample equals the previous
// accepted sample minus one, modulo 16.
//
// Tracking runs through three phases:
//   IDLE - take the first sample as the reference.
//   SYNC - count consecutive correct decrements until LOCK_N are seen.
//   LOCK - report a mismatch as err and a 0 -> 15 step as wrap.
//
// Ports:
//   clk      - system clock, rising edge
//   clr_bar  - synchronous active-low reset; it takes priority over everything
//   en       - sample strobe; Q3..Q0 are evaluated only while en=1
//   Q0..Q3   - counter bits (Q0 = LSB)
//   locked   - high while the sequence is tracked correctly
//   err      - one-cycle pulse on a decrement mismatch while locked
//   wrap     - one-cycle pulse on a 0000 -> 1111 step while locked
//   err_cnt  - number of err pulses, saturating at all-ones
//   wrap_cnt - number of wrap pulses, wrapping modulo 2^WRAP_W
//   last_q   - most recently accepted sample {Q3,Q2,Q1,Q0}
module downcount_seq_checker #(
  parameter int LOCK_N = 3,  // legal range 1..15
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              clr_bar,
  input  logic              en,
  input  logic              Q0,
  input  logic              Q1,
  input  logic              Q2,
  input  logic              Q3,
  output logic              locked,
  output logic              err,
  output logic              wrap,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [3:0]        last_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t      state_r;
  logic [3:0]  run_r;
  logic [3:0]  q_s;
  logic [3:0]  exp_s;
  logic [3:0]  run_inc_s;
  logic        match_s;

  // Expected value: the 4-bit result wraps, so 0 decrements to 15.
  function automatic logic [3:0] dec4(input logic [3:0] v);
    return v - 4'd1;
  endfunction

  assign q_s       = {Q3, Q2, Q1, Q0};
  assign exp_s     = dec4(last_q);
  assign match_s   = (q_s == exp_s);
  assign run_inc_s = run_r + 4'd1;

  // Tracking state machine with registered status, pulse and counter outputs.
  always_ff @(posedge clk) begin
    if (!clr_bar) begin
      state_r  <= IDLE;
      run_r    <= 4'd0;
      locked   <= 1'b0;
      err      <= 1'b0;
      wrap     <= 1'b0;
      err_cnt  <= {ERR_W{1'b0}};
      wrap_cnt <= {WRAP_W{1'b0}};
      last_q   <= 4'd0;
    end else if (!en) begin
      // No sample on this edge: hold everything and drop the pulses.
      err  <= 1'b0;
      wrap <= 1'b0;
    end else begin
      err    <= 1'b0;
      wrap   <= 1'b0;
      // Every accepted sample becomes the new reference, including a mismatch.
      last_q <= q_s;
      case (state_r)
        IDLE: begin
          run_r   <= 4'd0;
          state_r <= SYNC;
        end
        SYNC: begin
          // While syncing, mismatches only restart the run and raise no pulse.
          if (match_s) begin
            run_r <= run_inc_s;
            if (run_inc_s == 4'(LOCK_N)) begin
              state_r <= LOCK;
              locked  <= 1'b1;
            end else begin
              state_r <= SYNC;
            end
          end else begin
            run_r   <= 4'd0;
            state_r <= SYNC;
          end
        end
        LOCK: begin
          if (match_s) begin
            state_r <= LOCK;
            // A correct step from 0 must land on 15: this is the terminal-count wrap.
            if (last_q == 4'd0) begin
              wrap     <= 1'b1;
              wrap_cnt <= wrap_cnt + WRAP_W'(1);
            end else begin
              wrap <= 1'b0;
            end
          end else begin
            err <= 1'b1;
            if (err_cnt != {ERR_W{1'b1}}) begin
              err_cnt <= err_cnt + ERR_W'(1);
            end else begin
              err_cnt <= err_cnt;
            end
            locked  <= 1'b0;
            run_r   <= 4'd0;
            state_r <= SYNC;
          end
        end
        default: begin
          state_r <= IDLE;
          run_r   <= 4'd0;
          locked  <= 1'b0;
        end
      endcase
    end
  end

endmodule
